// File: rtl/riscv_pkg.sv
// Shared definitions for the core's data-memory responder: MMIO register
// offsets (byte offsets inside the 256-byte MMIO window) and the address
// region classification used by the decoder.
package riscv_pkg;

  localparam logic [7:0] CYCLE_LO       = 8'h00;
  localparam logic [7:0] CYCLE_HI       = 8'h04;
  localparam logic [7:0] CONSOLE_DATA   = 8'h08;
  localparam logic [7:0] CONSOLE_STATUS = 8'h0C;
  localparam logic [7:0] CONSOLE_DROPS  = 8'h10;
  localparam logic [7:0] FAULT_ADDR     = 8'h14;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_UNMAPPED
  } mem_region_e;

endpackage

// File: rtl/console_fifo.sv
// Console transmit FIFO: circular buffer with its own pointers and count.
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset (flushes the FIFO)
//   push, push_data   enqueue request (ignored while full)
//   pop               dequeue request (ignored while empty)
//   head_data         oldest entry, 0 while empty
//   full, empty       state flags derived from the registered count
//   occupancy         number of stored entries, 0..DEPTH
module console_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign occupancy = count;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale entries are never visible past the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/data_bus_responder.sv
// Responder for the single-cycle core's data-memory port. Decodes each
// word access into word RAM, a 64-bit cycle counter, or the console FIFO
// registers. Reads are combinational; writes commit on the rising edge.
// Optional feature macro: DATA_BUS_RESPONDER_FAULT_EN adds the sticky
// bus_fault output and the FAULT_ADDR register.
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   memory_write_enable   store strobe
//   memory_address        byte address (bits [1:0] ignored)
//   memory_write_data     store data
//   memory_read_data      load data, combinational
//   console_valid/data    console byte stream head (valid/ready)
//   bus_fault             sticky unmapped-access flag (feature macro only)
//   console_ready         sink accepts the head byte
module data_bus_responder
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     RAM_BYTES     = 4096,
  parameter logic [XLEN-1:0] MMIO_BASE     = 32'hF000_0000,
  parameter int unsigned     CONSOLE_DEPTH = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            memory_write_enable,
  input  logic [XLEN-1:0] memory_address,
  input  logic [XLEN-1:0] memory_write_data,
  output logic [XLEN-1:0] memory_read_data,
  output logic            console_valid,
  output logic [7:0]      console_data,
`ifdef DATA_BUS_RESPONDER_FAULT_EN
  output logic            bus_fault,
`endif
  input  logic            console_ready
);

  localparam int unsigned RAM_AW      = $clog2(RAM_BYTES);
  localparam int unsigned RAM_WORDS   = RAM_BYTES / 4;
  localparam int unsigned IDX_W       = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned RAM_ENTRIES = 2 ** IDX_W;
  localparam int unsigned OCC_W       = $clog2(CONSOLE_DEPTH) + 1;

  mem_region_e      region;
  logic [7:0]       offset;
  logic             ram_hit;
  logic             mmio_hit;
  logic             reg_hit;
  logic [IDX_W-1:0] ram_idx;

  logic [XLEN-1:0]  ram_mem [RAM_ENTRIES];
  logic [63:0]      cycle_count;
  logic [31:0]      console_drops;

  logic             console_write;
  logic             console_push;
  logic             console_pop;
  logic             console_full;
  logic             console_empty;
  logic [OCC_W-1:0] console_occ;
  logic [XLEN-1:0]  console_status;

`ifdef DATA_BUS_RESPONDER_FAULT_EN
  logic [XLEN-1:0]  fault_addr;
  logic             fault_clear;
`endif

  // Address decode; holes inside the MMIO window count as unmapped.
  always_comb begin
    offset   = {memory_address[7:2], 2'b00};
    ram_idx  = memory_address[IDX_W+1:2];
    ram_hit  = ((memory_address >> RAM_AW) == '0);
    mmio_hit = (memory_address[XLEN-1:8] == MMIO_BASE[XLEN-1:8]);
`ifdef DATA_BUS_RESPONDER_FAULT_EN
    reg_hit  = offset inside {CYCLE_LO, CYCLE_HI, CONSOLE_DATA, CONSOLE_STATUS,
                              CONSOLE_DROPS, FAULT_ADDR};
`else
    reg_hit  = offset inside {CYCLE_LO, CYCLE_HI, CONSOLE_DATA, CONSOLE_STATUS,
                              CONSOLE_DROPS};
`endif
    region = REGION_UNMAPPED;
    if (ram_hit)                   region = REGION_RAM;
    else if (mmio_hit && reg_hit)  region = REGION_MMIO;
  end

  // Word RAM: not reset, so contents survive n_rst.
  always_ff @(posedge clk) begin
    if (memory_write_enable && (region == REGION_RAM)) ram_mem[ram_idx] <= memory_write_data;
  end

  // Free-running cycle counter; reads see the pre-increment value.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cycle_count <= '0;
    else        cycle_count <= cycle_count + 64'd1;
  end

  // Fullness is the registered state, so a push while full drops even if
  // the sink pops in the same cycle.
  assign console_write = memory_write_enable && (region == REGION_MMIO) && (offset == CONSOLE_DATA);
  assign console_push  = console_write && !console_full;
  assign console_valid = !console_empty;
  assign console_pop   = console_valid && console_ready;

  console_fifo #(
    .WIDTH (8),
    .DEPTH (CONSOLE_DEPTH)
  ) u_console_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (console_push),
    .push_data (memory_write_data[7:0]),
    .pop       (console_pop),
    .head_data (console_data),
    .full      (console_full),
    .empty     (console_empty),
    .occupancy (console_occ)
  );

  // Saturating count of dropped console pushes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                       console_drops <= '0;
    else if (console_write && console_full && (console_drops != '1)) console_drops <= console_drops + 32'd1;
  end

  assign console_status = XLEN'({8'(console_occ), 6'b0, console_empty, console_full});

`ifdef DATA_BUS_RESPONDER_FAULT_EN
  // Sticky fault: capture the first unmapped access; any write to FAULT_ADDR clears.
  assign fault_clear = memory_write_enable && (region == REGION_MMIO) && (offset == FAULT_ADDR);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus_fault  <= 1'b0;
      fault_addr <= '0;
    end else if (fault_clear) begin
      bus_fault  <= 1'b0;
      fault_addr <= '0;
    end else if ((region == REGION_UNMAPPED) && !bus_fault) begin
      bus_fault  <= 1'b1;
      fault_addr <= memory_address;
    end
  end
`endif

  // Combinational load data.
  always_comb begin
    memory_read_data = '0;
    case (region)
      REGION_RAM: memory_read_data = ram_mem[ram_idx];
      REGION_MMIO: begin
        case (offset)
          CYCLE_LO:       memory_read_data = XLEN'(cycle_count[31:0]);
          CYCLE_HI:       memory_read_data = XLEN'(cycle_count[63:32]);
          CONSOLE_STATUS: memory_read_data = console_status;
          CONSOLE_DROPS:  memory_read_data = XLEN'(console_drops);
`ifdef DATA_BUS_RESPONDER_FAULT_EN
          FAULT_ADDR:     memory_read_data = fault_addr;
`endif
          default:        memory_read_data = '0;
        endcase
      end
      default: memory_read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Randomized scoreboard bench for data_bus_responder against a queue/array
// reference model of the memory map, cycle counter and console stream.
module tb_data_bus_responder;

  localparam int unsigned RAM_BYTES = 4096;
  localparam int unsigned DEPTH     = 16;
  localparam logic [31:0] MMIO_BASE = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        memory_write_enable;
  logic [31:0] memory_address;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;
`ifdef DATA_BUS_RESPONDER_FAULT_EN
  logic        bus_fault;
`endif

  always #5 clk = ~clk;

  data_bus_responder #(
    .XLEN          (32),
    .RAM_BYTES     (RAM_BYTES),
    .MMIO_BASE     (MMIO_BASE),
    .CONSOLE_DEPTH (DEPTH)
  ) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .memory_write_enable (memory_write_enable),
    .memory_address      (memory_address),
    .memory_write_data   (memory_write_data),
    .memory_read_data    (memory_read_data),
    .console_valid       (console_valid),
    .console_data        (console_data),
`ifdef DATA_BUS_RESPONDER_FAULT_EN
    .bus_fault           (bus_fault),
`endif
    .console_ready       (console_ready)
  );

  // kind 0: load data, 1: {valid,data} of console head, 2: bus_fault
  typedef struct {
    int          kind;
    logic [31:0] exp;
    logic [31:0] addr;
  } chk_t;

  chk_t        sb[$];
  logic [7:0]  exp_con[$];

  // Reference model state
  logic [7:0]  m_fifo[$];
  logic [31:0] m_ram[int];
  logic [63:0] m_cyc;
  logic [31:0] m_drops;
  bit          m_fault;
  logic [31:0] m_faddr;

  int n_cmp = 0;
  int n_err = 0;

  function automatic bit is_ram(logic [31:0] a);
    return a < RAM_BYTES;
  endfunction

  function automatic bit is_reg(logic [31:0] a);
    if (a[31:8] != MMIO_BASE[31:8]) return 1'b0;
    if (a[7:0] < 8'h14) return 1'b1;
`ifdef DATA_BUS_RESPONDER_FAULT_EN
    if (a[7:0] < 8'h18) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_read(logic [31:0] a);
    int sz;
    sz = m_fifo.size();
    if (is_ram(a)) return m_ram[int'(a >> 2)];
    if (!is_reg(a)) return 32'h0;
    case (a[7:2])
      6'd0: return m_cyc[31:0];
      6'd1: return m_cyc[63:32];
      6'd3: return {16'h0, 8'(sz), 6'h0, (sz == 0), (sz == int'(DEPTH))};
      6'd4: return m_drops;
      6'd5: return m_faddr;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One bus cycle: drive, queue expectations from the pre-edge model, advance model.
  task automatic cycle(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    bit         do_push;
    logic [7:0] head;
    chk_t       c;
    do_push = 1'b0;
    memory_write_enable = we;
    memory_address      = a;
    memory_write_data   = wd;
    console_ready       = rdy;
    if (!is_ram(a) || m_ram.exists(int'(a >> 2))) begin
      c.kind = 0; c.exp = exp_read(a); c.addr = a;
      sb.push_back(c);
    end
    head = (m_fifo.size() > 0) ? m_fifo[0] : 8'h00;
    c.kind = 1; c.exp = {23'h0, (m_fifo.size() > 0), head}; c.addr = a;
    sb.push_back(c);
`ifdef DATA_BUS_RESPONDER_FAULT_EN
    c.kind = 2; c.exp = {31'h0, m_fault}; c.addr = a;
    sb.push_back(c);
`endif
    if (we) begin
      if (is_ram(a)) m_ram[int'(a >> 2)] = wd;
      else if (is_reg(a) && a[7:2] == 6'd2) begin
        if (m_fifo.size() == int'(DEPTH)) begin
          if (m_drops != 32'hFFFF_FFFF) m_drops++;
        end else do_push = 1'b1;
      end
`ifdef DATA_BUS_RESPONDER_FAULT_EN
      else if (is_reg(a) && a[7:2] == 6'd5) begin
        m_fault = 1'b0;
        m_faddr = 32'h0;
      end
`endif
    end
`ifdef DATA_BUS_RESPONDER_FAULT_EN
    if (!is_ram(a) && !is_reg(a) && !m_fault) begin
      m_fault = 1'b1;
      m_faddr = a;
    end
`endif
    if (rdy && m_fifo.size() > 0) exp_con.push_back(m_fifo.pop_front());
    if (do_push) m_fifo.push_back(wd[7:0]);
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_cyc   = 64'h0;
    m_drops = 32'h0;
    m_fault = 1'b0;
    m_faddr = 32'h0;
  endtask

  // Monitor: compare queued expectations mid-cycle and every completed pop.
  always @(negedge clk) begin
    chk_t c;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      n_cmp++;
      case (c.kind)
        0: if (memory_read_data !== c.exp) begin
             n_err++;
             $display("FAIL rdata addr=%h: got %h expected %h", c.addr, memory_read_data, c.exp);
           end
        1: if ({console_valid, console_data} !== c.exp[8:0]) begin
             n_err++;
             $display("FAIL console_head: got valid=%b data=%h expected valid=%b data=%h",
                      console_valid, console_data, c.exp[8], c.exp[7:0]);
           end
        default: begin
`ifdef DATA_BUS_RESPONDER_FAULT_EN
          if (bus_fault !== c.exp[0]) begin
            n_err++;
            $display("FAIL bus_fault addr=%h: got %b expected %b", c.addr, bus_fault, c.exp[0]);
          end
`endif
        end
      endcase
    end
    if (n_rst && console_valid && console_ready) begin
      n_cmp++;
      if (exp_con.size() == 0) begin
        n_err++;
        $display("FAIL console_pop: got unexpected byte %h expected none", console_data);
      end else if (console_data !== exp_con[0]) begin
        n_err++;
        $display("FAIL console_pop: got %h expected %h", console_data, exp_con.pop_front());
      end else begin
        void'(exp_con.pop_front());
      end
    end
  end

  localparam logic [31:0] A_LO     = MMIO_BASE + 32'h00;
  localparam logic [31:0] A_HI     = MMIO_BASE + 32'h04;
  localparam logic [31:0] A_CDATA  = MMIO_BASE + 32'h08;
  localparam logic [31:0] A_STAT   = MMIO_BASE + 32'h0C;
  localparam logic [31:0] A_DROPS  = MMIO_BASE + 32'h10;
  localparam logic [31:0] A_FAULT  = MMIO_BASE + 32'h14;

  function automatic logic [31:0] rand_ram_addr();
    int w;
    w = $urandom_range(0, 64);
    if (w == 64) return 32'(RAM_BYTES - 4) | 32'($urandom_range(0, 3));
    return 32'(w * 4) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] a;
    n_rst = 1'b0;
    memory_write_enable = 1'b0;
    memory_address = A_LO;
    memory_write_data = 32'h0;
    console_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_console_valid", {31'h0, console_valid}, 32'h0);
    check("reset_console_data", {24'h0, console_data}, 32'h0);
    check("reset_cycle_lo", memory_read_data, 32'h0);
    memory_address = 32'h0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_reset();

    // Ten clocks after release, CYCLE_LO reads 10
    repeat (10) cycle(1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, A_LO, 32'h0, 1'b0);
    cycle(1'b0, A_HI, 32'h0, 1'b0);

    // Fill part of RAM with random words, including the last word
    for (int i = 0; i < 64; i++) cycle(1'b1, 32'(i * 4), $urandom, 1'b0);
    cycle(1'b1, 32'(RAM_BYTES - 4), $urandom, 1'b0);

    // Word access ignores addr[1:0]; neighbouring word untouched
    cycle(1'b1, 32'h14, 32'h1234_5678, 1'b0);
    cycle(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b0, 32'h10, 32'h0, 1'b0);
    cycle(1'b0, 32'h13, 32'h0, 1'b0);
    cycle(1'b0, 32'h14, 32'h0, 1'b0);

    // Overfill the console with the sink stalled: 16 stored, 1 dropped
    for (int i = 0; i < 17; i++) cycle(1'b1, A_CDATA, 32'(8'h41 + i), 1'b0);
    cycle(1'b0, A_STAT, 32'h0, 1'b0);
    cycle(1'b0, A_DROPS, 32'h0, 1'b0);
    cycle(1'b0, A_CDATA, 32'h0, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b0);

    // Drain in order, then empty
    repeat (17) cycle(1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, A_STAT, 32'h0, 1'b0);

    // Occupancy 3, then simultaneous push and pop
    for (int i = 0; i < 3; i++) cycle(1'b1, A_CDATA, 32'(8'h60 + i), 1'b0);
    cycle(1'b1, A_CDATA, 32'h63, 1'b1);
    cycle(1'b0, A_STAT, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);

    // Reset mid-drain: stream stops at once, RAM survives
    n_rst = 1'b0;
    memory_address = 32'h0;
    console_ready = 1'b1;
    #1;
    check("midreset_console_valid", {31'h0, console_valid}, 32'h0);
    check("midreset_ram0", memory_read_data, m_ram[0]);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_reset();
    cycle(1'b0, 32'h10, 32'h0, 1'b1);
    cycle(1'b0, A_STAT, 32'h0, 1'b0);

    // Unmapped accesses and fault capture/clear
    cycle(1'b0, 32'h8000_0000, 32'h0, 1'b0);
    cycle(1'b0, 32'h9000_0000, 32'h0, 1'b0);
    cycle(1'b0, A_FAULT, 32'h0, 1'b0);
    cycle(1'b1, A_FAULT, 32'h0, 1'b0);
    cycle(1'b0, A_FAULT, 32'h0, 1'b0);
    cycle(1'b0, 32'(RAM_BYTES), 32'h0, 1'b0);
    cycle(1'b0, MMIO_BASE + 32'h18, 32'h0, 1'b0);
    cycle(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    cycle(1'b1, A_LO, 32'hFFFF_FFFF, 1'b0);
    cycle(1'b0, A_LO, 32'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit rdy;
      rdy = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1: cycle(1'b1, rand_ram_addr(), $urandom, rdy);
        2, 3: cycle(1'b0, rand_ram_addr(), 32'h0, rdy);
        4, 5: cycle(1'b1, A_CDATA, $urandom, rdy);
        6:    cycle(1'b0, MMIO_BASE + 32'($urandom_range(0, 7) * 4), 32'h0, rdy);
        7: begin
          case ($urandom_range(0, 2))
            0:       a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
            1:       a = 32'(RAM_BYTES) + 32'($urandom_range(0, 15) * 4);
            default: a = MMIO_BASE + 32'h40 + 32'($urandom_range(0, 15) * 4);
          endcase
          cycle(1'($urandom_range(0, 1)), a, $urandom, rdy);
        end
        8:    cycle(1'b1, MMIO_BASE + 32'($urandom_range(0, 5) * 4), $urandom, rdy);
        default: cycle(1'b0, 32'h0, 32'h0, rdy);
      endcase
    end

    // Flush remaining bytes and confirm nothing left unmatched
    repeat (40) cycle(1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, A_STAT, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    check("console_bytes_outstanding", 32'(exp_con.size()), 32'h0);
    check("checks_outstanding", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
